pulse_decoder: RTL and testbench

Sequential 3-to-8 one-hot decoder. It turns a stream of 3-bit codes, in the format produced by the 8-to-3 priority encoder, back into timed one-hot strobes. Incoming codes are buffered in a small FIFO. Each code is replayed as a one-hot `dout` pulse of fixed length, followed by a fixed idle gap. The block sits on the receive side of the encoder path and drives downstream per-line select/enable logic.

---
 rtl/pulse_decoder.sv | 144 ++++++++++++++
 tb/tb_pulse_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pulse_decoder.sv
// Replays buffered 3-bit codes as one-hot strobes: each pulse lasts HOLD cycles and is followed by GAP idle cycles.
// Codes are queued in a DEPTH-entry FIFO and replayed in arrival order.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | dout is zero; pops the FIFO head as soon as count != 0
//   S_PULSE | one-hot dout held while the hold counter runs down to 0
//   S_GAP   | dout is zero while the gap counter runs down to 0
module pulse_decoder #(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [7:0]                 dout,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LD  = 8'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_dout;
    logic [7:0]      w_dout_nxt;
    logic [7:0]      r_hold_cnt;
    logic [7:0]      w_hold_nxt;
    logic [7:0]      r_gap_cnt;
    logic [7:0]      w_gap_nxt;
    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_head_onehot;

    // Ready depends only on the registered count: no bypass from a same-cycle pop.
    assign din_ready     = (r_count < CW'(DEPTH));
    assign w_push        = din_valid && din_ready;
    assign w_head_onehot = 8'd1 << r_mem[r_rd_ptr];

    assign dout  = r_dout;
    assign count = r_count;
    assign busy  = (r_state != S_IDLE) || (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dout_nxt = '0;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_dout_nxt  = w_head_onehot;
                    w_hold_nxt  = HOLD_LD;
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (r_hold_cnt == '0) begin
                    if (GAP > 0) begin
                        w_dout_nxt  = '0;
                        w_gap_nxt   = GAP_LD;
                        w_state_nxt = S_GAP;
                    end else if (r_count != '0) begin
                        // Back-to-back replay: next strobe follows with no zero cycle.
                        w_pop      = 1'b1;
                        w_dout_nxt = w_head_onehot;
                        w_hold_nxt = HOLD_LD;
                    end else begin
                        w_dout_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt - 8'd1;
                end
            end
            S_GAP: begin
                w_dout_nxt = '0;
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_dout_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dout     <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dout     <= w_dout_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_pulse_decoder.sv
// Drives two decoder configurations with shared stimulus and compares them against a
// schedule-level reference: a queue of accepted codes plus the edge at which each pulse started.
module tb_pulse_decoder;

    localparam int HP [2] = '{4, 2};
    localparam int GP [2] = '{1, 0};
    localparam int DP [2] = '{4, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] din;
    logic       din_valid;
    logic       ready_a, ready_b;
    logic [7:0] dout_a, dout_b;
    logic       busy_a, busy_b;
    logic [2:0] count_a;
    logic [1:0] count_b;

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit started = 0;

    int ring [2][16];
    int head [2];
    int size [2];
    int last_pop [2];
    int cur [2];

    always #5 clk = ~clk;

    pulse_decoder #(.HOLD(4), .GAP(1), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_a), .dout(dout_a), .busy(busy_a), .count(count_a)
    );

    pulse_decoder #(.HOLD(2), .GAP(0), .DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_b), .dout(dout_b), .busy(busy_b), .count(count_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=0x%0h expected=0x%0h", tag, n, obs, exp);
        end
    endtask

    // Edge rules: a pop may start a pulse once the previous pulse (plus gap and,
    // with a gap, one idle cycle) has elapsed; pushes are accepted when not full.
    task automatic model_edge(input int k, input logic r, input logic v, input logic [2:0] d);
        int sb;
        int hb;
        if (r) begin
            size[k]     = 0;
            head[k]     = 0;
            last_pop[k] = -1000;
            return;
        end
        sb = size[k];
        hb = head[k];
        if (sb > 0 && n >= last_pop[k] + HP[k] + GP[k] + ((GP[k] > 0) ? 1 : 0)) begin
            cur[k]      = ring[k][hb];
            head[k]     = (hb + 1) % 16;
            size[k]     = size[k] - 1;
            last_pop[k] = n;
        end
        if (v && sb < DP[k]) begin
            ring[k][(hb + sb) % 16] = int'(d);
            size[k] = size[k] + 1;
        end
    endtask

    function automatic int exp_dout(input int k);
        if (n >= last_pop[k] && n < last_pop[k] + HP[k]) return 1 << cur[k];
        return 0;
    endfunction

    function automatic int exp_busy(input int k);
        return (size[k] > 0 || n < last_pop[k] + HP[k] + GP[k]) ? 1 : 0;
    endfunction

    task automatic step(input logic r, input logic v, input logic [2:0] d);
        rst = r; din_valid = v; din = d;
        #1;
        if (started) begin
            chk("ready_a", int'(ready_a), (size[0] < DP[0]) ? 1 : 0);
            chk("ready_b", int'(ready_b), (size[1] < DP[1]) ? 1 : 0);
        end
        @(posedge clk);
        model_edge(0, r, v, d);
        model_edge(1, r, v, d);
        @(negedge clk);
        chk("dout_a",  int'(dout_a),  exp_dout(0));
        chk("count_a", int'(count_a), size[0]);
        chk("busy_a",  int'(busy_a),  exp_busy(0));
        chk("dout_b",  int'(dout_b),  exp_dout(1));
        chk("count_b", int'(count_b), size[1]);
        chk("busy_b",  int'(busy_b),  exp_busy(1));
        n++;
        started = 1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 3'd0);
    endtask

    // Source holds the code until the reference says the default instance can take it.
    task automatic push_hold(input logic [2:0] d);
        bit ok;
        for (int t = 0; t < 60; t++) begin
            ok = (size[0] < DP[0]);
            step(1'b0, 1'b1, d);
            if (ok) return;
        end
        chk("push_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; din = 3'd0;
        for (int k = 0; k < 2; k++) begin
            size[k] = 0; head[k] = 0; last_pop[k] = -1000; cur[k] = 0;
        end

        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0);
        idle(2);

        // Single code
        step(1'b0, 1'b1, 3'd5);
        idle(10);

        // Sweep all codes back-to-back
        for (int c = 0; c < 8; c++) push_hold(3'(c));
        din_valid = 1'b0;
        idle(50);

        // Fill the FIFO while holding valid
        for (int c = 0; c < 6; c++) push_hold(3'(c));
        idle(45);

        // Back-to-back pair (exercises gapless replay on the second instance)
        push_hold(3'd3);
        push_hold(3'd6);
        idle(20);

        // Reset mid-pulse with codes queued, then a fresh push
        push_hold(3'd1);
        push_hold(3'd2);
        push_hold(3'd4);
        push_hold(3'd7);
        step(1'b1, 1'b1, 3'd6);
        step(1'b1, 1'b0, 3'd0);
        idle(2);
        step(1'b0, 1'b1, 3'd2);
        idle(10);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)));
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
